// File: rtl/proc_gen_if.sv
// Instruction/bus interface of the simple multi-cycle processor.
interface proc_gen_if #(
    parameter int unsigned W = 9
);
    logic         Run;
    logic [W-1:0] DIN;
    logic         Done;
    logic [W-1:0] BusWires;
    logic         Z;
    logic         C;

    modport master (output Run, DIN, input Done, BusWires, Z, C);
    modport slave  (input Run, DIN, output Done, BusWires, Z, C);
endinterface

// File: rtl/proc_gen.sv
// Multi-cycle processor: eight GPRs, one shared bus, an A/G ALU and a T0..T3 step counter.
// mv/mvi/mvnz finish in T1; add/sub/and/or/xor finish in T3.
module proc_gen #(
    parameter int unsigned W = 9
) (
    input  logic       Clock,
    input  logic       Resetn,
    proc_gen_if.slave  bus_if
);
    localparam int unsigned NREG = 8;
    localparam int unsigned IRW  = 9;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

    step_e          step_q;
    logic [W-1:0]   regs_q [NREG];
    logic [W-1:0]   a_q;
    logic [W-1:0]   g_q;
    logic [IRW-1:0] ir_q;
    logic           z_q;
    logic           c_q;
    logic           done_q;

    logic [2:0]     op;
    logic [2:0]     rx;
    logic [2:0]     ry;
    logic [2:0]     din_op;
    logic [W-1:0]   bus_c;
    logic [W:0]     alu_c;

    assign op     = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];
    assign din_op = bus_if.DIN[W-1:W-3];

    function automatic logic is_alu(input logic [2:0] o);
        return (o >= OP_ADD) && (o <= OP_XOR);
    endfunction

    // Bus source select; nothing drives the bus in T0
    always_comb begin
        bus_c = '0;
        case (step_q)
            T1: begin
                if (op == OP_MVI)                        bus_c = bus_if.DIN;
                else if (op == OP_MV || op == OP_MVNZ)   bus_c = regs_q[ry];
                else                                     bus_c = regs_q[rx];
            end
            T2:      bus_c = regs_q[ry];
            T3:      bus_c = g_q;
            default: bus_c = '0;
        endcase
    end

    // ALU result with carry/borrow in the extra top bit
    always_comb begin
        alu_c = '0;
        case (op)
            OP_ADD:  alu_c = {1'b0, a_q} + {1'b0, bus_c};
            OP_SUB:  alu_c = {1'b0, a_q} - {1'b0, bus_c};
            OP_AND:  alu_c = {1'b0, a_q & bus_c};
            OP_OR:   alu_c = {1'b0, a_q | bus_c};
            OP_XOR:  alu_c = {1'b0, a_q ^ bus_c};
            default: alu_c = '0;
        endcase
    end

    // Step sequencer and datapath registers; Done is registered one step ahead
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            a_q    <= '0;
            g_q    <= '0;
            ir_q   <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (step_q)
                T0: begin
                    if (bus_if.Run) begin
                        ir_q   <= bus_if.DIN[W-1:W-IRW];
                        step_q <= T1;
                        done_q <= !is_alu(din_op);
                    end
                end
                T1: begin
                    if (is_alu(op)) begin
                        a_q    <= bus_c;
                        step_q <= T2;
                    end else begin
                        if (op != OP_MVNZ || !z_q) regs_q[rx] <= bus_c;
                        step_q <= T0;
                    end
                end
                T2: begin
                    g_q    <= alu_c[W-1:0];
                    z_q    <= (alu_c[W-1:0] == '0);
                    c_q    <= alu_c[W];
                    done_q <= 1'b1;
                    step_q <= T3;
                end
                T3: begin
                    regs_q[rx] <= bus_c;
                    step_q     <= T0;
                end
                default: step_q <= T0;
            endcase
        end
    end

    assign bus_if.BusWires = bus_c;
    assign bus_if.Done     = done_q;
    assign bus_if.Z        = z_q;
    assign bus_if.C        = c_q;
endmodule

// File: tb/tb_proc_gen.sv
// Directed bench for proc_gen (W=9): reset, moves, ALU ops, flags, aborts and Run handling.
module tb_proc_gen;
    localparam int unsigned W = 9;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    proc_gen_if #(.W(W)) pif ();

    proc_gen #(.W(W)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus_if (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] x, input logic [W-1:0] val);
        pif.Run = 1'b1;
        pif.DIN = {3'b001, x, 3'b000};
        tick();
        pif.DIN = val;
        pif.Run = 1'b0;
        tick();
    endtask

    task automatic alu(input logic [8:0] ins);
        pif.Run = 1'b1;
        pif.DIN = ins;
        tick();
        pif.Run = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pif.Run = 1'b0;
        pif.DIN = '0;
        #2;
        total++; if (pif.BusWires !== 9'd0) begin bad++; $display("FAIL rst_bus got=%0h want=0", pif.BusWires); end
        total++; if (pif.Done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", pif.Done); end
        total++; if ({pif.Z, pif.C} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b want=00", {pif.Z, pif.C}); end
        for (int i = 0; i < 8; i++) begin
            total++; if (dut.regs_q[i] !== 9'd0) begin bad++; $display("FAIL rst_r%0d got=%0h want=0", i, dut.regs_q[i]); end
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_mvi();
        pif.Run = 1'b1;
        pif.DIN = 9'b001_000_000;
        tick();
        total++; if (pif.Done !== 1'b1) begin bad++; $display("FAIL mvi_done got=%b want=1", pif.Done); end
        pif.DIN = 9'd5;
        #1;
        total++; if (pif.BusWires !== 9'd5) begin bad++; $display("FAIL mvi_bus got=%0h want=5", pif.BusWires); end
        pif.Run = 1'b0;
        tick();
        total++; if (dut.regs_q[0] !== 9'd5) begin bad++; $display("FAIL mvi_r0 got=%0h want=5", dut.regs_q[0]); end
        total++; if (pif.Done !== 1'b0) begin bad++; $display("FAIL mvi_done_low got=%b want=0", pif.Done); end
        total++; if (pif.BusWires !== 9'd0) begin bad++; $display("FAIL mvi_t0_bus got=%0h want=0", pif.BusWires); end
    endtask

    task automatic test_add();
        load(3'd1, 9'd7);
        pif.Run = 1'b1;
        pif.DIN = 9'b010_000_001;
        tick();
        total++; if (pif.Done !== 1'b0) begin bad++; $display("FAIL add_t1_done got=%b want=0", pif.Done); end
        total++; if (pif.BusWires !== 9'd5) begin bad++; $display("FAIL add_t1_bus got=%0h want=5", pif.BusWires); end
        pif.Run = 1'b0;
        tick();
        total++; if (pif.Done !== 1'b0) begin bad++; $display("FAIL add_t2_done got=%b want=0", pif.Done); end
        total++; if (pif.BusWires !== 9'd7) begin bad++; $display("FAIL add_t2_bus got=%0h want=7", pif.BusWires); end
        tick();
        total++; if (pif.Done !== 1'b1) begin bad++; $display("FAIL add_t3_done got=%b want=1", pif.Done); end
        total++; if (pif.BusWires !== 9'd12) begin bad++; $display("FAIL add_t3_bus got=%0h want=c", pif.BusWires); end
        tick();
        total++; if (dut.regs_q[0] !== 9'd12) begin bad++; $display("FAIL add_r0 got=%0h want=c", dut.regs_q[0]); end
        total++; if (dut.regs_q[1] !== 9'd7) begin bad++; $display("FAIL add_r1 got=%0h want=7", dut.regs_q[1]); end
        total++; if ({pif.Z, pif.C} !== 2'b00) begin bad++; $display("FAIL add_flags got=%b want=00", {pif.Z, pif.C}); end
        total++; if (pif.Done !== 1'b0) begin bad++; $display("FAIL add_done_low got=%b want=0", pif.Done); end
    endtask

    task automatic test_sub();
        load(3'd0, 9'd3);
        load(3'd1, 9'd5);
        alu(9'b011_000_001);
        total++; if (dut.regs_q[0] !== 9'h1FE) begin bad++; $display("FAIL sub_r0 got=%0h want=1fe", dut.regs_q[0]); end
        total++; if ({pif.Z, pif.C} !== 2'b01) begin bad++; $display("FAIL sub_flags got=%b want=01", {pif.Z, pif.C}); end
        load(3'd0, 9'd256);
        total++; if ({pif.Z, pif.C} !== 2'b01) begin bad++; $display("FAIL mvi_keeps_flags got=%b want=01", {pif.Z, pif.C}); end
        alu(9'b010_000_000);
        total++; if (dut.regs_q[0] !== 9'd0) begin bad++; $display("FAIL add_wrap_r0 got=%0h want=0", dut.regs_q[0]); end
        total++; if ({pif.Z, pif.C} !== 2'b11) begin bad++; $display("FAIL add_wrap_flags got=%b want=11", {pif.Z, pif.C}); end
    endtask

    task automatic test_mvnz();
        load(3'd3, 9'd9);
        load(3'd2, 9'd4);
        pif.Run = 1'b1;
        pif.DIN = 9'b111_010_011;
        tick();
        total++; if (pif.Done !== 1'b1) begin bad++; $display("FAIL mvnz_done got=%b want=1", pif.Done); end
        total++; if (pif.BusWires !== 9'd9) begin bad++; $display("FAIL mvnz_bus got=%0h want=9", pif.BusWires); end
        pif.Run = 1'b0;
        tick();
        total++; if (dut.regs_q[2] !== 9'd4) begin bad++; $display("FAIL mvnz_z1_r2 got=%0h want=4", dut.regs_q[2]); end
        load(3'd4, 9'd1);
        load(3'd5, 9'd2);
        alu(9'b101_100_101);
        total++; if (dut.regs_q[4] !== 9'd3) begin bad++; $display("FAIL or_r4 got=%0h want=3", dut.regs_q[4]); end
        total++; if ({pif.Z, pif.C} !== 2'b00) begin bad++; $display("FAIL or_flags got=%b want=00", {pif.Z, pif.C}); end
        pif.Run = 1'b1;
        pif.DIN = 9'b111_010_011;
        tick();
        pif.Run = 1'b0;
        tick();
        total++; if (dut.regs_q[2] !== 9'd9) begin bad++; $display("FAIL mvnz_z0_r2 got=%0h want=9", dut.regs_q[2]); end
    endtask

    task automatic test_reset_mid();
        load(3'd0, 9'd1);
        load(3'd1, 9'd2);
        pif.Run = 1'b1;
        pif.DIN = 9'b010_000_001;
        tick();
        pif.Run = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (pif.Done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", pif.Done); end
        total++; if (pif.BusWires !== 9'd0) begin bad++; $display("FAIL abort_bus got=%0h want=0", pif.BusWires); end
        total++; if (dut.regs_q[0] !== 9'd0 || dut.regs_q[1] !== 9'd0 || dut.regs_q[2] !== 9'd0) begin
            bad++; $display("FAIL abort_regs got=%0h/%0h/%0h want=0/0/0", dut.regs_q[0], dut.regs_q[1], dut.regs_q[2]);
        end
        total++; if (dut.step_q !== 2'd0) begin bad++; $display("FAIL abort_step got=%0d want=0", dut.step_q); end
        #1;
        rst_n = 1'b1;
        pif.DIN = 9'b001_111_000;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pif.Done !== 1'b0) begin bad++; $display("FAIL idle_done cyc=%0d got=%b want=0", i, pif.Done); end
            total++; if (dut.ir_q !== 9'd0) begin bad++; $display("FAIL idle_ir cyc=%0d got=%0h want=0", i, dut.ir_q); end
        end
        pif.Run = 1'b1;
        tick();
        total++; if (pif.Done !== 1'b1) begin bad++; $display("FAIL post_rst_t0 got=%b want=1", pif.Done); end
        pif.Run = 1'b0;
        pif.DIN = 9'h0AB;
        tick();
        total++; if (dut.regs_q[7] !== 9'h0AB) begin bad++; $display("FAIL post_rst_r7 got=%0h want=ab", dut.regs_q[7]); end
    endtask

    task automatic test_xor_run_drop();
        load(3'd6, 9'h1A5);
        load(3'd7, 9'h0F0);
        pif.Run = 1'b1;
        pif.DIN = 9'b110_110_111;
        tick();
        tick();
        total++; if (pif.Done !== 1'b0) begin bad++; $display("FAIL xor_t2_done got=%b want=0", pif.Done); end
        pif.Run = 1'b0;
        tick();
        total++; if (pif.Done !== 1'b1) begin bad++; $display("FAIL xor_t3_done got=%b want=1", pif.Done); end
        total++; if (pif.BusWires !== 9'h155) begin bad++; $display("FAIL xor_bus got=%0h want=155", pif.BusWires); end
        tick();
        total++; if (dut.regs_q[6] !== 9'h155) begin bad++; $display("FAIL xor_r6 got=%0h want=155", dut.regs_q[6]); end
        total++; if (dut.regs_q[7] !== 9'h0F0) begin bad++; $display("FAIL xor_r7 got=%0h want=f0", dut.regs_q[7]); end
        total++; if ({pif.Z, pif.C} !== 2'b00) begin bad++; $display("FAIL xor_flags got=%b want=00", {pif.Z, pif.C}); end
    endtask

    task automatic test_back_to_back();
        pif.Run = 1'b1;
        pif.DIN = 9'b000_101_110;
        tick();
        total++; if (pif.Done !== 1'b1) begin bad++; $display("FAIL mv_done got=%b want=1", pif.Done); end
        total++; if (pif.BusWires !== 9'h155) begin bad++; $display("FAIL mv_bus got=%0h want=155", pif.BusWires); end
        pif.DIN = 9'b011_111_111;
        tick();
        total++; if (dut.regs_q[5] !== 9'h155) begin bad++; $display("FAIL mv_r5 got=%0h want=155", dut.regs_q[5]); end
        total++; if (pif.BusWires !== 9'd0 || pif.Done !== 1'b0) begin
            bad++; $display("FAIL b2b_t0 got=%0h/%b want=0/0", pif.BusWires, pif.Done);
        end
        tick();
        pif.Run = 1'b0;
        tick();
        tick();
        tick();
        total++; if (dut.regs_q[7] !== 9'd0) begin bad++; $display("FAIL subxx_r7 got=%0h want=0", dut.regs_q[7]); end
        total++; if ({pif.Z, pif.C} !== 2'b10) begin bad++; $display("FAIL subxx_flags got=%b want=10", {pif.Z, pif.C}); end
        total++; if (dut.regs_q[6] !== 9'h155) begin bad++; $display("FAIL subxx_r6 got=%0h want=155", dut.regs_q[6]); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mvi();
        test_add();
        test_sub();
        test_mvnz();
        test_reset_mid();
        test_xor_run_drop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
